// File: rtl/fnd_scan_ctrl_if.sv
// Host-side bus of the FND scan controller: display content in, digit/segment drive and strobes out.
// The controller sits on the slave modport; whatever feeds it uses master.
interface fnd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS*4-1:0] i_data;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [NUM_DIGITS-1:0]   i_blink;
  logic                    i_lzb;
  logic [3:0]              i_bright;
  logic                    i_load;
  logic                    o_load_ack;
  logic                    o_frame_start;
  logic [NUM_DIGITS-1:0]   fnd_com;
  logic [7:0]              fnd_data;

  modport master (
    output i_data, i_dp, i_blink, i_lzb, i_bright, i_load,
    input  o_load_ack, o_frame_start, fnd_com, fnd_data
  );

  modport slave (
    input  i_data, i_dp, i_blink, i_lzb, i_bright, i_load,
    output o_load_ack, o_frame_start, fnd_com, fnd_data
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scanner: one digit per slot, guard/on/off PWM inside each slot,
// double-buffered content committed only at frame boundaries; blink, DP and leading-zero blanking.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100_000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic           clk,
  input  logic           reset,
  fnd_scan_ctrl_if.slave bus
);
  localparam int CW  = $clog2(TICK_DIV);
  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int FW  = $clog2(BLINK_FRAMES + 1);
  localparam int SUB = TICK_DIV / 16;
  localparam int DW  = NUM_DIGITS * 4;
  localparam logic [DW-1:0] BLANK_DATA = {NUM_DIGITS{4'hE}};

  typedef enum logic [1:0] {GUARD, ON, OFF} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frm_q, frm_d;
  logic                  hide_q, hide_d;
  logic                  pend_q, pend_d;
  logic [3:0]            bright_q, bright_d;
  logic [DW-1:0]         sh_data_q, act_data_q;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_blink_q, act_dp_q, act_blink_q;
  logic                  sh_lzb_q, act_lzb_q;

  logic                  slot_end, frame_end, commit;
  logic [3:0]            sub_d;
  logic [3:0]            nib;
  logic                  lz_run, lz_blank, hidden;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] com;
  logic [7:0]            dat;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hF: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  assign slot_end  = (cnt_q == CW'(TICK_DIV - 1));
  assign frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
  assign commit    = frame_end && pend_q;

  always_comb begin
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    frm_d    = frm_q;
    hide_d   = hide_q;
    bright_d = (cnt_q == '0) ? bus.i_bright : bright_q;
    pend_d   = bus.i_load ? 1'b1 : (commit ? 1'b0 : pend_q);
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + IW'(1);
    end
    if (frame_end) begin
      if (frm_q == FW'(BLINK_FRAMES - 1)) begin
        frm_d  = '0;
        hide_d = ~hide_q;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
  end

  // Next state looks at the subtick of the upcoming count; brightness was latched on cycle 0 of the guard.
  always_comb begin
    state_d = state_q;
    sub_d   = 4'(int'(cnt_d) / SUB);
    case (state_q)
      GUARD:   if (sub_d != 4'd0) state_d = (bright_q != 4'd0) ? ON : OFF;
      ON:      if (sub_d == 4'd0) state_d = GUARD;
               else if (sub_d > bright_q) state_d = OFF;
      OFF:     if (sub_d == 4'd0) state_d = GUARD;
      default: state_d = GUARD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= GUARD;
      cnt_q       <= '0;
      idx_q       <= '0;
      frm_q       <= '0;
      hide_q      <= 1'b0;
      pend_q      <= 1'b0;
      bright_q    <= 4'd0;
      sh_data_q   <= BLANK_DATA;
      sh_dp_q     <= '0;
      sh_blink_q  <= '0;
      sh_lzb_q    <= 1'b0;
      act_data_q  <= BLANK_DATA;
      act_dp_q    <= '0;
      act_blink_q <= '0;
      act_lzb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frm_q    <= frm_d;
      hide_q   <= hide_d;
      pend_q   <= pend_d;
      bright_q <= bright_d;
      if (bus.i_load) begin
        sh_data_q  <= bus.i_data;
        sh_dp_q    <= bus.i_dp;
        sh_blink_q <= bus.i_blink;
        sh_lzb_q   <= bus.i_lzb;
      end
      // Reads the pre-edge shadow, so a load landing on this cycle waits a frame.
      if (commit) begin
        act_data_q  <= sh_data_q;
        act_dp_q    <= sh_dp_q;
        act_blink_q <= sh_blink_q;
        act_lzb_q   <= sh_lzb_q;
      end
    end
  end

  always_comb begin
    nib    = act_data_q[int'(idx_q)*4 +: 4];
    lz_run = 1'b1;
    for (int d = 1; d < NUM_DIGITS; d++) begin
      if (d >= int'(idx_q) && act_data_q[d*4 +: 4] != 4'd0) lz_run = 1'b0;
    end
    lz_blank = act_lzb_q && (idx_q != '0) && lz_run;
    hidden   = hide_q && act_blink_q[idx_q];
    seg      = lz_blank ? 7'h7F : decode(nib);
    com      = '1;
    dat      = 8'hFF;
    if (state_q == ON) begin
      com[idx_q] = 1'b0;
      if (!hidden) dat = {~act_dp_q[idx_q], seg};
    end
  end

  assign bus.fnd_com       = com;
  assign bus.fnd_data      = dat;
  assign bus.o_load_ack    = commit;
  assign bus.o_frame_start = reset && (cnt_q == '0) && (idx_q == '0);
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboarded bench for fnd_scan_ctrl (4 digits, 32-cycle slots, 2-frame blink half-period).
// Stimulus queues per-slot display expectations and ack frames; the monitor checks them as slots complete.
module tb_fnd_scan_ctrl;
  localparam int ND = 4;
  localparam int TD = 32;
  localparam int BF = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fnd_scan_ctrl_if #(.NUM_DIGITS(ND)) bus();

  fnd_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .TICK_DIV    (TD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int         frame;
    int         digit;
    logic [7:0] data;
    int         on_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mon_frame = -1;
  int   mon_pos   = 0;
  bit   was_rst   = 1'b1;
  bit   timed_out = 1'b0;

  int         slot, digit, on_cnt;
  logic [7:0] on_data;
  logic [3:0] exp_com;
  bit         clean;
  exp_t       e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {18'd0, bus.o_frame_start, bus.o_load_ack, bus.fnd_com, bus.fnd_data},
            {18'd0, 2'b00, 4'hF, 8'hFF});
      mon_frame = -1;
      mon_pos   = 0;
      was_rst   = 1'b1;
    end else begin
      if (was_rst) begin
        check("first_frame_start", {31'd0, bus.o_frame_start}, 32'd1);
        was_rst = 1'b0;
      end
      if (bus.o_frame_start) begin
        mon_frame++;
        mon_pos = 0;
      end else if (mon_frame >= 0) begin
        mon_pos++;
      end
      if (mon_frame >= 0) begin
        slot    = mon_pos % TD;
        digit   = mon_pos / TD;
        exp_com = ~(4'b0001 << digit);
        if (slot == 0) begin
          on_cnt  = 0;
          on_data = 8'hFF;
          clean   = 1'b1;
        end
        if (bus.fnd_com != 4'hF) begin
          if (slot < 2 || bus.fnd_com != exp_com) clean = 1'b0;
          if (on_cnt == 0) on_data = bus.fnd_data;
          else if (bus.fnd_data != on_data) clean = 1'b0;
          on_cnt++;
        end else if (bus.fnd_data != 8'hFF) begin
          clean = 1'b0;
        end
        if (slot == TD - 1 && exp_q.size() > 0 && exp_q[0].frame == mon_frame && exp_q[0].digit == digit) begin
          e = exp_q.pop_front();
          check($sformatf("f%0d_d%0d_data", e.frame, e.digit), {24'd0, on_data}, {24'd0, e.data});
          check($sformatf("f%0d_d%0d_on_cycles", e.frame, e.digit), on_cnt, e.on_cyc);
          check($sformatf("f%0d_d%0d_guard_off_clean", e.frame, e.digit), {31'd0, clean}, 32'd1);
        end
      end
      if (bus.o_load_ack) begin
        if (ack_q.size() == 0) check("unexpected_ack", {31'd0, bus.o_load_ack}, 32'd0);
        else check("ack_frame", mon_frame, ack_q.pop_front());
      end
    end
  end

  task automatic wait_at(input int f, input int p);
    int n;
    n = 0;
    if (timed_out) return;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(mon_frame == f && mon_pos == p) && n < 5000);
    if (!(mon_frame == f && mon_pos == p)) begin
      timed_out = 1'b1;
      check($sformatf("wait_f%0d_p%0d", f, p), mon_frame * 1000 + mon_pos, f * 1000 + p);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] blink, input logic lzb);
    bus.i_data  = d;
    bus.i_dp    = dp;
    bus.i_blink = blink;
    bus.i_lzb   = lzb;
    bus.i_load  = 1'b1;
    @(negedge clk);
    #1;
    bus.i_load  = 1'b0;
  endtask

  // d packs the expected segment bytes as {digit3, digit2, digit1, digit0}.
  task automatic exp_frame(input int f, input logic [31:0] d, input int on_cyc, input int ndig);
    for (int i = 0; i < ndig; i++) exp_q.push_back('{f, i, d[i*8 +: 8], on_cyc});
  endtask

  initial begin
    bus.i_data   = '0;
    bus.i_dp     = '0;
    bus.i_blink  = '0;
    bus.i_lzb    = 1'b0;
    bus.i_bright = 4'd15;
    bus.i_load   = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    exp_frame(0, 32'hFFFF_FFFF, 30, ND);
    ack_q.push_back(0);
    exp_frame(1, 32'hF9A4_B099, 30, ND);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_at(0, 10);
    load(16'h1234, 4'b0000, 4'b0000, 1'b0);

    wait_at(1, 100);
    bus.i_bright = 4'd4;
    exp_frame(2, 32'hF9A4_B099, 8, ND);

    wait_at(2, 100);
    bus.i_bright = 4'd0;
    exp_frame(3, 32'hFFFF_FFFF, 0, ND);

    wait_at(3, 100);
    bus.i_bright = 4'd15;
    load(16'h0070, 4'b0010, 4'b0000, 1'b1);
    ack_q.push_back(3);
    exp_frame(4, 32'hFFFF_78C0, 30, ND);

    wait_at(4, 100);
    load(16'h5678, 4'b0000, 4'b0001, 1'b0);
    ack_q.push_back(4);
    exp_frame(5, 32'h9282_F880, 30, ND);
    exp_frame(6, 32'h9282_F8FF, 30, ND);
    exp_frame(7, 32'h9282_F8FF, 30, ND);
    exp_frame(8, 32'h9282_F880, 30, ND);

    wait_at(8, 10);
    load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    wait_at(8, 50);
    load(16'h2222, 4'b0000, 4'b0000, 1'b0);
    ack_q.push_back(8);
    exp_frame(9, 32'hA4A4_A4A4, 30, ND);

    wait_at(9, 50);
    load(16'h4444, 4'b0000, 4'b0000, 1'b0);
    ack_q.push_back(9);
    ack_q.push_back(10);
    exp_frame(10, 32'h9999_9999, 30, ND);
    exp_frame(11, 32'hB0B0_B0B0, 30, 2);
    wait_at(9, 127);
    load(16'h3333, 4'b0000, 4'b0000, 1'b0);

    wait_at(11, 40);
    load(16'h5555, 4'b0000, 4'b0000, 1'b0);
    wait_at(11, 70);
    rst_n = 1'b0;
    #1;
    check("reset_immediate", {20'd0, bus.fnd_com, bus.fnd_data}, {20'd0, 4'hF, 8'hFF});
    repeat (3) @(negedge clk);
    exp_frame(0, 32'hFFFF_FFFF, 30, ND);
    exp_frame(1, 32'hFFFF_FFFF, 30, ND);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_at(2, 0);

    check("exp_queue_drained", exp_q.size(), 32'd0);
    check("ack_queue_drained", ack_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 Parameter TICK_DIV, default 100_000, clk cycles per digit slot (multiple of 16, >=32).
REQ-003 Parameter BLINK_FRAMES, default 125, full frames per blink half-period (>=1).
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 i_data  in  NUM_DIGITS*4  BCD nibble per digit, digit 0 = bits [3:0] = rightmost.
REQ-007 i_dp  in  NUM_DIGITS  decimal-point enable per digit.
REQ-008 i_blink  in  NUM_DIGITS  blink enable per digit.
REQ-009 i_lzb  in  1  leading-zero blanking enable.
REQ-010 i_bright  in  4  brightness, 0 = dark, 15 = max.
REQ-011 i_load  in  1  one-cycle strobe: capture i_data/i_dp/i_blink/i_lzb into shadow.
REQ-012 o_load_ack  out  1  one-cycle pulse when shadow is committed to the active set.
REQ-013 o_frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot.
REQ-014 fnd_com  out  NUM_DIGITS  digit common, active-low, at most one bit low.
REQ-015 fnd_data  out  8  segments {dp,g..a}, active-low.

Function
REQ-016 Slot counter counts 0..TICK_DIV-1, then wraps; on wrap, digit index advances 0..NUM_DIGITS-1, wrapping to 0.
REQ-017 Slot is divided into 16 subticks of TICK_DIV/16 cycles; subtick index = slot count / (TICK_DIV/16).
REQ-018 Per-slot FSM: GUARD (subtick 0) -> ON (subticks 1..i_bright) -> OFF (remaining subticks) -> GUARD of next digit.
REQ-019 GUARD and OFF: fnd_com all ones, fnd_data 8'hFF.
REQ-020 ON: fnd_com bit[index] low, fnd_data = decoded segments of the active digit.
REQ-021 i_bright = 0: ON never entered; i_bright = 15: ON covers subticks 1..15. i_bright sampled at each GUARD, held for the slot.
REQ-022 Decode: 0..9 standard (0 = 8'hC0 .. 9 = 8'h90), 0xA..0xE blank (segments off), 0xF minus (g only).
REQ-023 DP: fnd_data[7] = 0 when active dp bit set, independent of blanking.
REQ-024 LZB: when active lzb = 1, zero nibbles from digit NUM_DIGITS-1 downward are blanked until the first non-zero nibble; digit 0 is never blanked.
REQ-025 Blink: frame counter counts completed frames; phase toggles every BLINK_FRAMES frames; in hidden phase, digits with blink bit set show 8'hFF (DP also off), com still driven.
REQ-026 Load: i_load copies inputs into shadow and sets pending; i_load while pending overwrites shadow (last wins).
REQ-027 Commit: on the cycle digit index wraps NUM_DIGITS-1 -> 0, if pending: shadow -> active, pending cleared, o_load_ack = 1 for that cycle.
REQ-028 i_load on the commit cycle: commit uses the old shadow; new data stays pending for the next frame.
REQ-029 No tearing: active set changes only at frame boundary.
REQ-030 o_frame_start = 1 exactly when index = 0 and slot count = 0.

Reset
REQ-031 While reset = 0: all counters 0, index 0, blink phase visible, pending 0, shadow and active data = all 0xE, dp/blink/lzb = 0.
REQ-032 While reset = 0: fnd_com all ones, fnd_data 8'hFF, o_load_ack 0, o_frame_start 0.
REQ-033 Reset asserted mid-slot or mid-pending takes effect immediately; pending load is discarded.
REQ-034 First cycle after release: slot 0 of digit 0 (GUARD), o_frame_start = 1.

Verification (NUM_DIGITS=4, TICK_DIV=32, BLINK_FRAMES=2)
REQ-035 Load 16'h1234, i_bright=15, no dp -> after ack, digit 0 shows 8'h99 and digit 3 shows 8'hF9 for cycles 2..31 of the slot; guard cycles 0..1 show 8'hFF with all com high.
REQ-036 i_bright=4 -> per slot, com low exactly 8 cycles (subticks 1..4); i_bright=0 -> com all ones for the whole frame.
REQ-037 Load 16'h0070, lzb=1, dp=4'b0010 -> digits 3,2 blank, digit 1 = 8'hF8 with bit7 low, digit 0 = 8'hC0.
REQ-038 Blink=4'b0001 -> digit 0 visible frames 0-1, 8'hFF frames 2-3, visible frames 4-5; other digits are unaffected.
REQ-039 Two i_load strobes in one frame (16'h1111 then 16'h2222) -> a single o_load_ack at the next boundary, display = 2222; i_load on the commit cycle -> second ack one frame later.
REQ-040 Reset pulled low mid-slot with load pending -> outputs go to 8'hFF/all ones immediately; after release, no ack occurs and the display is blank.
